// File: rtl/fp_align_shifter.sv
// fp_align_shifter: serial right-shift alignment of a mantissa, producing round and sticky bits
module fp_align_shifter #(
  parameter int W     = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     mant_in,
  input  logic [CNT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     mant_out,
  output logic             markr,
  output logic             marks
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic fast;
  // Shifts longer than W+1 push every bit past the round position into sticky
  assign fast = shamt > CNT_W'(W + 1);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (fast ? DONE : SHIFT) : IDLE;
      SHIFT:   state_nxt = (cnt == '0) ? DONE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt      <= '0;
      mant_out <= '0;
      markr    <= 1'b0;
      marks    <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt      <= shamt;
      mant_out <= fast ? '0 : mant_in;
      markr    <= 1'b0;
      marks    <= fast ? |mant_in : 1'b0;
    end else if (state == SHIFT && cnt != '0) begin
      cnt      <= cnt - CNT_W'(1);
      mant_out <= mant_out >> 1;
      markr    <= mant_out[0];
      marks    <= marks | markr;
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_fp_align_shifter.sv
// tb_fp_align_shifter: directed checks of latency, alignment results, fast path, busy-ignore and reset abort
module tb_fp_align_shifter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] mant_in = '0;
  logic [7:0]  shamt = '0;
  logic        busy, done, markr, marks;
  logic [23:0] mant_out;
  int tests = 0;
  int fails = 0;

  fp_align_shifter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mant_in(mant_in), .shamt(shamt),
    .busy(busy), .done(done), .mant_out(mant_out), .markr(markr), .marks(marks)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues start in cycle 0 (optionally re-pulses it mid-op), waits for done, checks
  // latency and results, then checks the following cycle holds results with no done.
  task automatic run_op(input string tag, input logic [23:0] m, input logic [7:0] sh,
                        input int exp_cyc, input logic [23:0] exp_m,
                        input logic exp_r, input logic exp_s, input int repulse);
    int cyc = 0;
    int dones = 0;
    mant_in = m;
    shamt = sh;
    start = 1'b1;
    while (dones == 0 && cyc < 200) begin
      step();
      cyc++;
      start = (repulse != 0 && cyc == repulse);
      if (cyc == repulse) mant_in = 24'h0;
      if (cyc == 1) chk({tag, ".busy1"}, 32'(busy), 32'd1);
      if (done) dones++;
    end
    chk({tag, ".cycle"}, cyc, exp_cyc);
    chk({tag, ".mant"}, 32'(mant_out), 32'(exp_m));
    chk({tag, ".markr"}, 32'(markr), 32'(exp_r));
    chk({tag, ".marks"}, 32'(marks), 32'(exp_s));
    start = 1'b0;
    step();
    chk({tag, ".done_once"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".hold"}, {7'd0, mant_out, markr}, {7'd0, exp_m, exp_r});
    chk({tag, ".hold_s"}, 32'(marks), 32'(exp_s));
  endtask

  initial begin
    int seen;
    step();
    step();
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.out", {6'd0, mant_out, markr, marks}, 32'd0);
    rst_n = 1'b1;
    step();
    run_op("t1_sh0",    24'hC00001, 8'd0,  2,  24'hC00001, 1'b0, 1'b0, 0);
    run_op("t2_sh2",    24'h800003, 8'd2,  4,  24'h200000, 1'b1, 1'b1, 0);
    run_op("t3_tie",    24'h800002, 8'd2,  4,  24'h200000, 1'b1, 1'b0, 0);
    run_op("t4_fast",   24'h800000, 8'd30, 1,  24'h000000, 1'b0, 1'b1, 0);
    run_op("t4_fast0",  24'h000000, 8'd30, 1,  24'h000000, 1'b0, 1'b0, 0);
    run_op("t5_shW",    24'hFFFFFF, 8'd24, 26, 24'h000000, 1'b1, 1'b1, 5);
    run_op("shW_r0",    24'h7FFFFF, 8'd24, 26, 24'h000000, 1'b0, 1'b1, 0);
    run_op("shW1",      24'h800000, 8'd25, 27, 24'h000000, 1'b0, 1'b1, 0);
    run_op("fast26",    24'h000001, 8'd26, 1,  24'h000000, 1'b0, 1'b1, 0);
    run_op("sh5",       24'hABCDEF, 8'd5,  7,  24'h055E6F, 1'b0, 1'b1, 0);
    // Abort mid-shift with reset, then confirm no done ever appears
    mant_in = 24'hFFFFFF;
    shamt = 8'd10;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      start = 1'b0;
      if (c == 3) rst_n = 1'b0;
    end
    chk("t6_rst.busy", 32'(busy), 32'd0);
    chk("t6_rst.out", {6'd0, mant_out, markr, marks}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) seen++;
      step();
    end
    chk("t6_rst.nodone", seen, 0);
    run_op("t6_after",  24'h800001, 8'd1,  3,  24'h400000, 1'b1, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
